// File: rtl/lcd_pkg.sv
// rtl/lcd_pkg.sv - shared constants, types and helpers for the HD44780-style bus receiver.
package lcd_pkg;

  localparam int INS_CLEAR   = 0;
  localparam int INS_HOME    = 1;
  localparam int INS_ENTRY   = 2;
  localparam int INS_DISPLAY = 3;
  localparam int INS_SHIFT   = 4;
  localparam int INS_FUNC    = 5;
  localparam int INS_CGRAM   = 6;
  localparam int INS_DDRAM   = 7;

  localparam int LCD_CELLS   = 32;
  localparam int LCD_ROW_LEN = 16;
  localparam int COL_W       = $clog2(LCD_ROW_LEN);
  localparam int CURSOR_W    = 5;

  localparam logic [6:0] LINE1_BASE = 7'h00;
  localparam logic [6:0] LINE2_BASE = 7'h40;

  typedef enum logic {CLR_IDLE, CLR_RUN} clr_state_e;

  function automatic logic [CURSOR_W-1:0] cursor_step(input logic [CURSOR_W-1:0] c,
                                                      input logic up);
    return up ? c + 1'b1 : c - 1'b1;
  endfunction

  // DDRAM address 0x40.. maps onto the second row of the 32-cell mirror.
  function automatic logic [CURSOR_W-1:0] ddram_to_cursor(input logic [7:0] d);
    return {((d[6:0] & LINE2_BASE) != LINE1_BASE), d[COL_W-1:0]};
  endfunction

endpackage

// File: rtl/lcd_rx_sampler.sv
// rtl/lcd_rx_sampler.sv - bus sampler with en falling-edge detect; LCD_RX_SYNC_EN adds a 2-flop synchronizer.
module lcd_rx_sampler (
  input  logic       clk,
  input  logic       reset,
  input  logic       en,
  input  logic       rs,
  input  logic [7:0] data_in,
  output logic       xfer,
  output logic       xfer_rs,
  output logic [7:0] xfer_data
);

  logic [9:0] bus_in;
  logic [9:0] s1;
  logic [9:0] s2;

`ifdef LCD_RX_SYNC_EN
  logic [9:0] sync1;
  logic [9:0] sync2;

  always_ff @(posedge clk) begin
    if (reset) begin
      sync1 <= '0;
      sync2 <= '0;
    end else begin
      sync1 <= {en, rs, data_in};
      sync2 <= sync1;
    end
  end

  assign bus_in = sync2;
`else
  assign bus_in = {en, rs, data_in};
`endif

  always_ff @(posedge clk) begin
    if (reset) begin
      s1 <= '0;
      s2 <= '0;
    end else begin
      s1 <= bus_in;
      s2 <= s1;
    end
  end

  // s2 still holds the values captured while en was high.
  assign xfer      = s2[9] & ~s1[9];
  assign xfer_rs   = s2[8];
  assign xfer_data = s2[7:0];

endmodule

// File: rtl/lcd_bus_receiver.sv
// rtl/lcd_bus_receiver.sv - LCD bus decoder with 2x16 display RAM mirror (LCD_RX_SYNC_EN selects input synchronizer).
module lcd_bus_receiver
  import lcd_pkg::*;
#(
  parameter logic [7:0] CLEAR_CHAR = 8'h20
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                en,
  input  logic                rs,
  input  logic [7:0]          data_in,
  input  logic [4:0]          rd_addr,
  output logic [7:0]          rd_data,
  output logic                char_valid,
  output logic [4:0]          char_addr,
  output logic [7:0]          char_out,
  output logic                cmd_valid,
  output logic [7:0]          cmd_out,
  output logic [CURSOR_W-1:0] cursor,
  output logic                display_on,
  output logic                two_line,
  output logic                busy,
  output logic                overrun
);

  logic       xfer;
  logic       xfer_rs;
  logic [7:0] xfer_data;

  lcd_rx_sampler u_sampler (
    .clk       (clk),
    .reset     (reset),
    .en        (en),
    .rs        (rs),
    .data_in   (data_in),
    .xfer      (xfer),
    .xfer_rs   (xfer_rs),
    .xfer_data (xfer_data)
  );

  clr_state_e          state;
  clr_state_e          state_next;
  logic [4:0]          clr_cnt;
  logic                inc_mode;
  logic                accept;
  logic                start_clear;
  logic                ram_we;
  logic [4:0]          ram_waddr;
  logic [7:0]          ram_wdata;
  logic [7:0]          ram [LCD_CELLS];

  assign busy        = (state == CLR_RUN);
  assign accept      = xfer && !busy;
  assign start_clear = accept && !xfer_rs && (xfer_data == 8'h01);

  always_ff @(posedge clk) begin
    if (reset) state <= CLR_RUN;
    else       state <= state_next;
  end

  always_comb begin
    state_next = state;
    case (state)
      CLR_IDLE: if (start_clear) state_next = CLR_RUN;
      CLR_RUN:  if (clr_cnt == 5'(LCD_CELLS - 1)) state_next = CLR_IDLE;
      default:  state_next = CLR_RUN;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset || start_clear) clr_cnt <= '0;
    else if (busy)            clr_cnt <= clr_cnt + 5'd1;
  end

  // Single write port: the clear sweep owns it whenever busy.
  always_comb begin
    ram_we    = 1'b0;
    ram_waddr = cursor;
    ram_wdata = xfer_data;
    if (busy) begin
      ram_we    = 1'b1;
      ram_waddr = clr_cnt;
      ram_wdata = CLEAR_CHAR;
    end else if (accept && xfer_rs) begin
      ram_we = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (ram_we) ram[ram_waddr] <= ram_wdata;
  end

  always_ff @(posedge clk) begin
    if (reset) rd_data <= '0;
    else       rd_data <= ram[rd_addr];
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      cursor     <= '0;
      display_on <= 1'b0;
      two_line   <= 1'b0;
      inc_mode   <= 1'b1;
      char_valid <= 1'b0;
      char_addr  <= '0;
      char_out   <= '0;
      cmd_valid  <= 1'b0;
      cmd_out    <= '0;
      overrun    <= 1'b0;
    end else begin
      char_valid <= 1'b0;
      cmd_valid  <= 1'b0;
      if (xfer && busy) overrun <= 1'b1;
      if (accept && xfer_rs) begin
        char_valid <= 1'b1;
        char_addr  <= cursor;
        char_out   <= xfer_data;
        cursor     <= cursor_step(cursor, inc_mode);
      end else if (accept) begin
        cmd_valid <= 1'b1;
        cmd_out   <= xfer_data;
        // Highest set bit selects the instruction.
        if (xfer_data[INS_DDRAM]) begin
          cursor <= ddram_to_cursor(xfer_data);
        end else if (xfer_data[INS_CGRAM]) begin
        end else if (xfer_data[INS_FUNC]) begin
          two_line <= xfer_data[3];
        end else if (xfer_data[INS_SHIFT]) begin
          if (!xfer_data[3]) cursor <= cursor_step(cursor, xfer_data[2]);
        end else if (xfer_data[INS_DISPLAY]) begin
          display_on <= xfer_data[2];
        end else if (xfer_data[INS_ENTRY]) begin
          inc_mode <= xfer_data[1];
        end else if (xfer_data[INS_HOME]) begin
          cursor <= '0;
        end else if (xfer_data[INS_CLEAR]) begin
          cursor   <= '0;
          inc_mode <= 1'b1;
        end
      end
    end
  end

endmodule

// File: tb/tb_lcd_bus_receiver.sv
// tb/tb_lcd_bus_receiver.sv - scoreboard bench for lcd_bus_receiver (honours LCD_RX_SYNC_EN).
module tb_lcd_bus_receiver;

`ifdef LCD_RX_SYNC_EN
  localparam int LAT = 4;
`else
  localparam int LAT = 2;
`endif

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       en = 1'b0;
  logic       rs = 1'b0;
  logic [7:0] data_in = 8'h00;
  logic [4:0] rd_addr = 5'd0;
  logic [7:0] rd_data;
  logic       char_valid;
  logic [4:0] char_addr;
  logic [7:0] char_out;
  logic       cmd_valid;
  logic [7:0] cmd_out;
  logic [4:0] cursor;
  logic       display_on;
  logic       two_line;
  logic       busy;
  logic       overrun;

  lcd_bus_receiver dut (
    .clk        (clk),
    .reset      (reset),
    .en         (en),
    .rs         (rs),
    .data_in    (data_in),
    .rd_addr    (rd_addr),
    .rd_data    (rd_data),
    .char_valid (char_valid),
    .char_addr  (char_addr),
    .char_out   (char_out),
    .cmd_valid  (cmd_valid),
    .cmd_out    (cmd_out),
    .cursor     (cursor),
    .display_on (display_on),
    .two_line   (two_line),
    .busy       (busy),
    .overrun    (overrun)
  );

  always #5 clk = ~clk;

  int tests = 0;
  int fails = 0;
  int cyc = 0;

  typedef struct {
    bit         is_char;
    logic [4:0] addr;
    logic [7:0] data;
    int         at;
  } exp_t;

  exp_t sb[$];
  exp_t mon_e;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  always @(negedge clk) begin
    if (!reset && (char_valid || cmd_valid)) begin
      if (sb.size() == 0) begin
        tests++;
        fails++;
        $display("FAIL unexpected_strobe: char_valid=%0b cmd_valid=%0b expected none",
                 char_valid, cmd_valid);
      end else begin
        mon_e = sb.pop_front();
        check("strobe_kind", {31'd0, char_valid}, {31'd0, mon_e.is_char});
        check("strobe_cycle", cyc, mon_e.at);
        if (mon_e.is_char) begin
          check("char_addr", {27'd0, char_addr}, {27'd0, mon_e.addr});
          check("char_out", {24'd0, char_out}, {24'd0, mon_e.data});
        end else begin
          check("cmd_out", {24'd0, cmd_out}, {24'd0, mon_e.data});
        end
      end
    end
  end

  task automatic send(input logic r, input logic [7:0] d, input bit accepted,
                      input logic [4:0] exp_addr);
    exp_t e;
    @(negedge clk);
    en = 1'b1; rs = r; data_in = d;
    repeat (2) @(negedge clk);
    en = 1'b0;
    if (accepted) begin
      e.is_char = r;
      e.addr    = exp_addr;
      e.data    = d;
      e.at      = cyc + LAT;
      sb.push_back(e);
    end
    repeat (2) @(negedge clk);
  endtask

  task automatic cmd(input logic [7:0] d);
    send(1'b0, d, 1'b1, 5'd0);
  endtask

  task automatic settle();
    repeat (6) @(negedge clk);
  endtask

  task automatic rd(input logic [4:0] a, output logic [7:0] v);
    @(negedge clk);
    rd_addr = a;
    @(negedge clk);
    v = rd_data;
  endtask

  task automatic check_all_clear(input string name);
    logic [7:0] v;
    for (int i = 0; i < 32; i++) begin
      rd(i[4:0], v);
      check(name, {24'd0, v}, 32'h20);
    end
  endtask

  task automatic wait_idle(input string name);
    int n;
    n = 0;
    while (busy && n < 200) begin
      @(negedge clk);
      n++;
    end
    check(name, {31'd0, busy}, 32'd0);
  endtask

  initial begin
    logic [7:0] v;
    int n;

    repeat (3) @(negedge clk);
    check("reset_cursor", {27'd0, cursor}, 32'd0);
    check("reset_busy", {31'd0, busy}, 32'd1);
    check("reset_rd_data", {24'd0, rd_data}, 32'd0);
    check("reset_overrun", {31'd0, overrun}, 32'd0);
    check("reset_display_on", {31'd0, display_on}, 32'd0);
    check("reset_two_line", {31'd0, two_line}, 32'd0);
    check("reset_strobes", {30'd0, char_valid, cmd_valid}, 32'd0);

    reset = 1'b0;
    n = 0;
    while (busy && n < 100) begin
      n++;
      @(negedge clk);
    end
    check("post_reset_busy_cycles", n, 32'd32);
    check_all_clear("post_reset_cell");
    check("post_reset_cursor", {27'd0, cursor}, 32'd0);

    cmd(8'h06);
    send(1'b1, 8'h48, 1'b1, 5'd0);
    send(1'b1, 8'h49, 1'b1, 5'd1);
    settle();
    rd(5'd0, v); check("ram0_H", {24'd0, v}, 32'h48);
    rd(5'd1, v); check("ram1_I", {24'd0, v}, 32'h49);
    check("cursor_after_HI", {27'd0, cursor}, 32'd2);

    cmd(8'hC5);
    send(1'b1, 8'h5A, 1'b1, 5'd21);
    settle();
    rd(5'd21, v); check("ram21_Z", {24'd0, v}, 32'h5A);
    check("cursor_after_Z", {27'd0, cursor}, 32'd22);

    cmd(8'h04);
    cmd(8'h80);
    send(1'b1, 8'h41, 1'b1, 5'd0);
    settle();
    rd(5'd0, v); check("ram0_A", {24'd0, v}, 32'h41);
    check("cursor_wrap_down", {27'd0, cursor}, 32'd31);
    check("overrun_still_clear", {31'd0, overrun}, 32'd0);

    cmd(8'h01);
    send(1'b1, 8'h51, 1'b0, 5'd0);
    settle();
    check("overrun_set", {31'd0, overrun}, 32'd1);
    wait_idle("clear_done");
    check_all_clear("after_clear_cell");
    check("cursor_after_clear", {27'd0, cursor}, 32'd0);

    send(1'b1, 8'h42, 1'b1, 5'd0);
    settle();
    check("clear_restores_increment", {27'd0, cursor}, 32'd1);
    cmd(8'h10);
    cmd(8'h10);
    settle();
    check("shift_left_wrap", {27'd0, cursor}, 32'd31);
    cmd(8'h14);
    settle();
    check("shift_right_wrap", {27'd0, cursor}, 32'd0);
    cmd(8'h18);
    settle();
    check("display_shift_ignored", {27'd0, cursor}, 32'd0);

    cmd(8'h0C);
    cmd(8'h38);
    settle();
    check("display_on", {31'd0, display_on}, 32'd1);
    check("two_line", {31'd0, two_line}, 32'd1);
    check("overrun_sticky", {31'd0, overrun}, 32'd1);

    repeat (10) @(negedge clk);
    check("scoreboard_drained", sb.size(), 32'd0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/lcd_bus_receiver.md
# lcd_bus_receiver

Receiving end of the HD44780-style 8-bit parallel LCD bus driven by `LCD_driver`: samples `en`/`rs`/`data_in`, decodes instructions and character writes on each `en` falling edge, and maintains a 2x16 display RAM mirror with cursor and display state. It serves as the display model in system benches and as a bus monitor on hardware. Contents are readable through a registered port.

## Interface
- `CLEAR_CHAR`, 8'h20: value written to every cell by clear and by reset.
- `clk`  in  1  system clock.
- `reset`  in  1  synchronous, active-high reset.
- `en`  in  1  LCD enable strobe; the transfer is latched on its falling edge.
- `rs`  in  1  register select: 0 = instruction, 1 = data.
- `data_in`  in  8  LCD data bus.
- `rd_addr`  in  5  display RAM read address; 0–15 is line 1, 16–31 is line 2.
- `rd_data`  out  8  display RAM read data; registered, 1-cycle latency.
- `char_valid`  out  1  1-cycle strobe when a data write commits.
- `char_addr`  out  5  cell written by the committing data write.
- `char_out`  out  8  byte written by the committing data write.
- `cmd_valid`  out  1  1-cycle strobe when an instruction commits.
- `cmd_out`  out  8  committed instruction byte.
- `cursor`  out  5  current address counter.
- `display_on`  out  1  display-control D bit.
- `two_line`  out  1  function-set N bit.
- `busy`  out  1  high while a clear sequence runs.
- `overrun`  out  1  sticky flag, set by any transfer that arrives while `busy` is high.

## Operation
- **Sampler.** Inputs are registered into stage s1, then s2. A falling edge is `s2.en==1 && s1.en==0`. The transfer uses `s2.rs` and `s2.data`, the values sampled while `en` was still high.
- **Data write (rs=1).**
  - Write `ram[cursor]`.
  - Strobe `char_valid` with `char_addr` = pre-update cursor.
  - Then move the cursor: +1 if increment mode, else −1, mod 32 (31→0, 0→31).
- **Instruction (rs=0).** Decoded by the highest set bit. Every instruction, including 0x00, pulses `cmd_valid`.
  - bit7, set DDRAM: `cursor = {d[6], d[3:0]}`; d[5:4] ignored.
  - bit6, set CGRAM: no state change.
  - bit5, function set: `two_line = d[3]`.
  - bit4, cursor/display shift: if d[3]=0, cursor ±1 mod 32 (+1 when d[2]=1); if d[3]=1, ignored.
  - bit3, display control: `display_on = d[2]`.
  - bit2, entry mode: increment mode = d[1].
  - bit1, return home: `cursor = 0`.
  - bit0, clear:
    - `cursor = 0`, increment mode = 1.
    - Start the clear sequence: write `CLEAR_CHAR` to cells 0..31, one per cycle.
- **Busy window.**
  - Any transfer decoded while `busy` is high is dropped: no RAM or state change, no strobe, and `overrun` is set.
  - A falling edge on the same cycle `busy` deasserts is accepted.
- **Reset.**
  - Outputs during reset: `cursor` 0, `display_on` 0, `two_line` 0, increment mode 1, strobes 0, `rd_data` 0, `overrun` 0, `busy` 1.
  - After reset releases, a clear sequence runs automatically.
  - Reset asserted mid-clear or mid-transfer aborts it, and the full 32-cycle clear restarts after release.

## Timing
- Without the macro, `char_valid` or `cmd_valid` is high in the cycle after the second rising `clk` edge that samples `en` low. With the macro, add 2 cycles.
- The clear sequence writes cell 0 in the cycle `cmd_valid` is high. `busy` is high from that cycle for exactly 32 cycles.
- A read of cell k returns the new value from the cycle after its write.
- `en` high and low phases must each be ≥2 clk cycles. Shorter pulses may be missed; no behaviour is specified for them.

## Configuration
- Macro: `LCD_RX_SYNC_EN`.
- Defined: a 2-flop synchronizer on `en`, `rs` and `data_in` ahead of s1, for a bus asynchronous to `clk`. Latency +2 cycles.
- Undefined: inputs go directly into s1; the bus must be synchronous to `clk`.

## Structure
- Package `lcd_pkg` holds:
  - instruction bit positions (CLEAR=0 … SET_DDRAM=7);
  - `LCD_CELLS=32`, `LCD_ROW_LEN=16`;
  - line base addresses 7'h00 and 7'h40;
  - the cursor width.
- Sub-module `lcd_rx_sampler`: optional synchronizer, s1/s2 stages, falling-edge strobe, latched `rs`/`data`.
- Top level: decoder, state registers, clear counter, RAM.

## Test plan
- Reset, then wait 32 cycles: `busy` falls; all 32 reads return 8'h20; `cursor`=0.
- Send 0x06, then data "H","I": `char_addr` 0 then 1; `ram[0]`=8'h48, `ram[1]`=8'h49; `cursor`=2.
- Send 0xC5, then data "Z": write lands at cell 21; `cursor`=22.
- Send 0x04, 0x80, then data "A": `ram[0]`=8'h41; `cursor`=31 (wrap).
- Send 0x01, then a data write 5 cycles later: the write is dropped and `overrun`=1; after 32 cycles every cell reads 8'h20.
- Send 0x0C, then 0x38: `display_on`=1, `two_line`=1, two `cmd_valid` pulses with `cmd_out` 8'h0C then 8'h38. Repeat with the macro defined: each strobe arrives 2 cycles later.
